// File: rtl/conv1_window_ctrl_if.sv
// Pixel-stream and window bus between the frame source, the window controller and conv1.
// The controller sits on the slave modport; the master modport is the source/consumer side.
interface conv1_window_ctrl_if #(
    parameter int CW = 5
);
    logic          pixel_in;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          pixel_0;
    logic          pixel_1;
    logic          pixel_2;
    logic          pixel_3;
    logic          pixel_4;
    logic          pixel_5;
    logic          pixel_6;
    logic          pixel_7;
    logic          pixel_8;
    logic          valid_in_buf;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;

    modport slave (
        input  pixel_in, pixel_valid,
        output pixel_ready,
        output pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
        output pixel_5, pixel_6, pixel_7, pixel_8,
        output valid_in_buf, out_row, out_col
    );

    modport master (
        output pixel_in, pixel_valid,
        input  pixel_ready,
        input  pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
        input  pixel_5, pixel_6, pixel_7, pixel_8,
        input  valid_in_buf, out_row, out_col
    );
endinterface

// File: rtl/conv1_window_ctrl.sv
// Raster-scan 3x3 window generator for the first binary conv layer of a 28x28 frame.
// Two line buffers plus a 3x3 shift window; every accepted pixel at col>=2,row>=2 emits one window.
module conv1_window_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int KSIZE = 3,
    parameter int CW    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    conv1_window_ctrl_if.slave   px,
    output logic                 busy,
    output logic                 frame_done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg;
    logic [CW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [CW-1:0] out_row_reg;
    logic [CW-1:0] out_col_reg;
    logic          valid_reg;
    logic          frame_done_reg;
    logic          win_out_reg [9];

    logic          lb1_reg [IMG_W];
    logic          lb2_reg [IMG_W];
    logic          sh_reg  [3][3];
    logic          sh_next [3][3];
    logic          col_new [3];

    logic accept;
    logic emit;
    logic last_pixel;

    assign px.pixel_ready = (state_reg == RUN);
    assign accept         = px.pixel_valid && (state_reg == RUN);
    assign emit           = accept && (row_reg >= CW'(KSIZE - 1)) && (col_reg >= CW'(KSIZE - 1));
    assign last_pixel     = accept && (row_reg == CW'(IMG_H - 1)) && (col_reg == CW'(IMG_W - 1));

    // The oldest tap of each line buffer is the same column one/two rows up.
    assign col_new[0] = lb2_reg[IMG_W-1];
    assign col_new[1] = lb1_reg[IMG_W-1];
    assign col_new[2] = px.pixel_in;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sh_row
            for (gj = 0; gj < 3; gj++) begin : g_sh_col
                if (gj < 2) begin : g_shift
                    assign sh_next[gi][gj] = sh_reg[gi][gj+1];
                end else begin : g_load
                    assign sh_next[gi][gj] = col_new[gi];
                end
                always_ff @(posedge clk) begin
                    if (accept) sh_reg[gi][gj] <= sh_next[gi][gj];
                end
            end
        end

        for (gi = 0; gi < IMG_W; gi++) begin : g_lb
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (accept) begin
                        lb1_reg[gi] <= px.pixel_in;
                        lb2_reg[gi] <= lb1_reg[IMG_W-1];
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (accept) begin
                        lb1_reg[gi] <= lb1_reg[gi-1];
                        lb2_reg[gi] <= lb2_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            out_row_reg    <= '0;
            out_col_reg    <= '0;
            valid_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            for (int k = 0; k < 9; k++) win_out_reg[k] <= 1'b0;
        end else begin
            valid_reg      <= emit;
            frame_done_reg <= last_pixel;
            // Window bits are forced to zero on non-emitting cycles.
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win_out_reg[3*i+j] <= emit ? sh_next[i][j] : 1'b0;
            if (emit) begin
                out_row_reg <= row_reg - CW'(KSIZE - 1);
                out_col_reg <= col_reg - CW'(KSIZE - 1);
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        row_reg   <= '0;
                        col_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col_reg == CW'(IMG_W - 1)) begin
                            col_reg <= '0;
                            if (row_reg != CW'(IMG_H - 1)) row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                        if (last_pixel) state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy            = (state_reg != IDLE);
    assign frame_done      = frame_done_reg;
    assign px.valid_in_buf = valid_reg;
    assign px.out_row      = out_row_reg;
    assign px.out_col      = out_col_reg;
    assign px.pixel_0      = win_out_reg[0];
    assign px.pixel_1      = win_out_reg[1];
    assign px.pixel_2      = win_out_reg[2];
    assign px.pixel_3      = win_out_reg[3];
    assign px.pixel_4      = win_out_reg[4];
    assign px.pixel_5      = win_out_reg[5];
    assign px.pixel_6      = win_out_reg[6];
    assign px.pixel_7      = win_out_reg[7];
    assign px.pixel_8      = win_out_reg[8];
endmodule

// File: tb/tb_conv1_window_ctrl.sv
// Directed bench for conv1_window_ctrl: full frames with and without pixel gaps, ignored starts,
// and asynchronous reset mid-frame, each window checked against an image-array reference.
module tb_conv1_window_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic frame_done;

    conv1_window_ctrl_if #(.CW(5)) bus ();

    conv1_window_ctrl #(.IMG_W(28), .IMG_H(28), .KSIZE(3), .CW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .px         (bus.slave),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         win_cnt;
    int         done_cnt;
    logic [8:0] win_4_7;
    bit         img [28][28];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] obs_win();
        return {bus.pixel_0, bus.pixel_1, bus.pixel_2, bus.pixel_3, bus.pixel_4,
                bus.pixel_5, bus.pixel_6, bus.pixel_7, bus.pixel_8};
    endfunction

    task automatic fill(input int mode);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                if (mode == 0)      img[r][c] = 1'((r + c) & 1);
                else if (mode == 1) img[r][c] = 1'($urandom_range(0, 1));
                else                img[r][c] = ((r * 3 + c * 5) % 7) < 3;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_in_run", bus.pixel_ready, 1);
    endtask

    // Streams img in raster order; start_at >= 0 pulses start while that accept is pending.
    task automatic stream(input bit gaps, input int max_acc, input int start_at);
        int r = 0, c = 0, n = 0, cyc = 0;
        bit acc, ev;
        logic [8:0] ew, ow;
        win_cnt  = 0;
        done_cnt = 0;
        while (n < max_acc && cyc < 4000) begin
            bus.pixel_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.pixel_in    = bus.pixel_valid ? img[r][c] : 1'($urandom_range(0, 1));
            start           = (start_at >= 0) && (n == start_at);
            acc             = bus.pixel_valid && bus.pixel_ready;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            ow = obs_win();
            if (acc) begin
                ev = (r >= 2) && (c >= 2);
                chk("valid_after_accept", bus.valid_in_buf, ev);
                chk("frame_done_pulse", frame_done, (r == 27 && c == 27));
                if (ev) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            ew[8 - (3 * i + j)] = img[r - 2 + i][c - 2 + j];
                    chk("window", ow, ew);
                    chk("out_row", bus.out_row, r - 2);
                    chk("out_col", bus.out_col, c - 2);
                    if (r == 6 && c == 9) win_4_7 = ow;
                    win_cnt++;
                end else begin
                    chk("window_zero", ow, 0);
                end
                if (frame_done) done_cnt++;
                n++;
                c++;
                if (c == 28) begin
                    c = 0;
                    r++;
                end
            end else begin
                chk("valid_no_accept", bus.valid_in_buf, 0);
                chk("frame_done_no_accept", frame_done, 0);
            end
        end
        bus.pixel_valid = 1'b0;
        chk("accepts_within_budget", n, max_acc);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, bus.pixel_ready, 0);
        chk({tag, "_valid"}, bus.valid_in_buf, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_row"}, bus.out_row, 0);
        chk({tag, "_col"}, bus.out_col, 0);
        chk({tag, "_win"}, obs_win(), 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", bus.pixel_ready, 0);

        // Frame 1: checkerboard, no gaps.
        fill(0);
        do_start();
        stream(1'b0, 784, -1);
        chk("f1_done_busy", busy, 1);
        chk("f1_done_valid", bus.valid_in_buf, 1);
        chk("f1_last_row", bus.out_row, 25);
        chk("f1_last_col", bus.out_col, 25);
        chk("f1_windows", win_cnt, 676);
        chk("f1_done_count", done_cnt, 1);
        chk("f1_win_4_7", win_4_7, 9'b101010101);
        // start during the DONE cycle must be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_start_idle_busy", busy, 0);
        chk("done_start_ready", bus.pixel_ready, 0);
        chk("idle_valid", bus.valid_in_buf, 0);
        chk("idle_done", frame_done, 0);
        chk("idle_hold_row", bus.out_row, 25);
        @(posedge clk); #1;
        chk("done_start_still_idle", busy, 0);

        // Frame 2: random image, ~50% gaps, start pulsed mid-frame.
        fill(1);
        do_start();
        stream(1'b1, 784, 300);
        chk("f2_windows", win_cnt, 676);
        chk("f2_done_count", done_cnt, 1);
        @(posedge clk); #1;
        chk("f2_back_idle", busy, 0);

        // Frame 3: reset after 400 accepts, then a clean frame.
        fill(2);
        do_start();
        stream(1'b1, 400, -1);
        chk("pre_reset_valid", bus.valid_in_buf, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("no_stale_valid", bus.valid_in_buf, 0);
        chk("no_restart_busy", busy, 0);
        fill(1);
        do_start();
        stream(1'b0, 784, -1);
        chk("f4_windows", win_cnt, 676);
        chk("f4_done_count", done_cnt, 1);
        @(posedge clk); #1;
        chk("f4_back_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
